mdu_scheduler: RTL
==================

Name: mdu_scheduler

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline in `mips`.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models fixed-latency busy periods.
- Owns the HI/LO registers.
- Drives the MDU stall request to the hazard unit for any D-stage instruction that touches the MDU, including MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  E-stage MDU instruction present this cycle.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved.
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source).
- rt_val  in  32  forwarded rt operand (divisor / multiplier).
- d_is_md  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  out  1  operation in flight.
- stall  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse after HI/LO commit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0. Pending result is discarded.
- States: IDLE, RUN.
- Only IDLE accepts ops. Pending HI/LO results are computed combinationally from rs_val/rt_val at the issue edge and held in pending registers.
- IDLE, op_valid, md_op in 0..3:
  - Latch the pending result.
  - cnt = MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3).
  - Go to RUN. busy=1 from the next cycle.
- RUN: cnt decrements each edge. On the edge where cnt==1, commit pending to hi/lo, busy drops, go to IDLE, done=1 for exactly the following cycle.
- Result: busy is high for exactly N cycles. hi/lo show the new value from cycle N+1 after issue (the issue edge is edge 0).
- IDLE, op_valid, md_op 4/5: write rs_val to hi or lo at the next edge. No busy, no done.
- MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero: full DIV_CYCLES busy period, hi/lo unchanged, done still pulses.
- op_valid in RUN: ignored; hi/lo/cnt unaffected. The stall logic makes this unreachable in a correct pipeline.
- Reserved md_op (6/7): ignored in all states.
- stall = d_is_md & (busy | (op_valid & md_op<=3)).
  - Combinational; covers the issue cycle itself.
  - Deasserts in the cycle after the commit edge, so a following MFHI sees the new value.
- done, busy, hi, lo are registered.

Optional Feature:
- MDU_CANCEL_EN defined:
  - Adds input port `cancel` (1 bit), used for exception flush.
  - cancel=1 in RUN: next edge goes to IDLE, busy=0, pending discarded, hi/lo unchanged, no done.
  - cancel=1 in IDLE suppresses any op issued that same cycle, including MTHI/MTLO.
  - cancel has priority over the commit edge: cancel with cnt==1 means no commit.
- MDU_CANCEL_EN not defined: no port. An issued op always completes unless reset.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MULTU rs=0xFFFFFFFF, rt=2, then DIV rs=0xFFFFFFF9 (-7), rt=2:
  - MULTU -> hi=1, lo=0xFFFFFFFE.
  - DIV -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=5, rt=0 with hi=lo=0x12345678 preloaded via MTHI/MTLO -> 10 busy cycles; hi/lo still 0x12345678; done pulses.
- MULT issued with d_is_md=1 (MFLO) held:
  - stall=1 on the issue cycle and all 5 busy cycles.
  - stall=0 on the cycle the new lo is visible.
  - A second op_valid MULT during RUN leaves the result unchanged.
- Assert reset on busy cycle 3 of DIV -> busy=0, hi=lo=0 immediately (asynchronous); no done afterward.
- MDU_CANCEL_EN: MULT 7*6, cancel on busy cycle 5 -> hi/lo keep old values, busy=0 next cycle, no done.

Source files
------------

// File: rtl/mdu_scheduler.sv
// mdu_scheduler
// Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
// It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the
// HI/LO registers. It also raises a stall request for any D-stage MDU
// instruction while an operation is in flight or being issued.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   op_valid  in   1   E-stage MDU instruction present this cycle
//   md_op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   rs_val    in  32   forwarded rs operand
//   rt_val    in  32   forwarded rt operand
//   d_is_md   in   1   D-stage instruction touches the MDU (incl. MFHI/MFLO)
//   cancel    in   1   exception flush (only when MDU_CANCEL_EN is defined)
//   busy      out  1   operation in flight
//   stall     out  1   stall request to the hazard unit
//   done      out  1   one-cycle pulse after the HI/LO commit
//   hi, lo    out 32   HI/LO registers
//
// Optional feature: define MDU_CANCEL_EN to add the cancel input.

module mdu_scheduler #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
`ifdef MDU_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      r_state, w_nextState;
   logic [3:0]  r_cnt, w_nextCnt;
   logic [31:0] r_pendHi, r_pendLo;
   logic [31:0] r_hi, r_lo;
   logic        r_done;

   logic        w_cancel;
   logic        w_issue, w_commit, w_wrHi, w_wrLo;
   logic [31:0] w_resHi, w_resLo;

`ifdef MDU_CANCEL_EN
   assign w_cancel = cancel;
`else
   assign w_cancel = 1'b0;
`endif

   // Products: the signed product is the low 64 bits of the product of
   // the sign-extended operands, so one unsigned multiplier form suffices.
   logic [63:0] w_sProd, w_uProd;
   assign w_sProd = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign w_uProd = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
   // to 0x80000000 instead of relying on simulator overflow behaviour.
   logic        w_divSigned, w_negA, w_negB, w_divZero;
   logic [31:0] w_magA, w_magB, w_safeB, w_q, w_r, w_quot, w_rem;
   assign w_divSigned = ~md_op[0];
   assign w_negA      = w_divSigned & rs_val[31];
   assign w_negB      = w_divSigned & rt_val[31];
   assign w_magA      = w_negA ? (~rs_val + 32'd1) : rs_val;
   assign w_magB      = w_negB ? (~rt_val + 32'd1) : rt_val;
   assign w_divZero   = (rt_val == 32'd0);
   assign w_safeB     = w_divZero ? 32'd1 : w_magB;
   assign w_q         = w_magA / w_safeB;
   assign w_r         = w_magA % w_safeB;
   assign w_quot      = (w_negA ^ w_negB) ? (~w_q + 32'd1) : w_q;
   assign w_rem       = w_negA ? (~w_r + 32'd1) : w_r;

   // Result captured into the pending registers at the issue edge. A divide
   // by zero latches the current HI/LO so the commit leaves them unchanged.
   always_comb begin
      w_resHi = r_hi;
      w_resLo = r_lo;
      case (md_op)
         3'd0: begin
            w_resHi = w_sProd[63:32];
            w_resLo = w_sProd[31:0];
         end
         3'd1: begin
            w_resHi = w_uProd[63:32];
            w_resLo = w_uProd[31:0];
         end
         3'd2, 3'd3: begin
            if (!w_divZero) begin
               w_resHi = w_rem;
               w_resLo = w_quot;
            end
         end
         default: ;
      endcase
   end

   // Next-state logic. Cancel outranks both issue and the final-count
   // commit; ops arriving while RUN are ignored.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_issue     = 1'b0;
      w_commit    = 1'b0;
      w_wrHi      = 1'b0;
      w_wrLo      = 1'b0;
      case (r_state)
         IDLE: begin
            if (op_valid && !w_cancel) begin
               case (md_op)
                  3'd0, 3'd1: begin
                     w_issue     = 1'b1;
                     w_nextState = RUN;
                     w_nextCnt   = 4'(MULT_CYCLES);
                  end
                  3'd2, 3'd3: begin
                     w_issue     = 1'b1;
                     w_nextState = RUN;
                     w_nextCnt   = 4'(DIV_CYCLES);
                  end
                  3'd4: w_wrHi = 1'b1;
                  3'd5: w_wrLo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (w_cancel) begin
               w_nextState = IDLE;
               w_nextCnt   = 4'd0;
            end else if (r_cnt == 4'd1) begin
               w_commit    = 1'b1;
               w_nextState = IDLE;
               w_nextCnt   = 4'd0;
            end else begin
               w_nextCnt = r_cnt - 4'd1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State, counter, pending result and the architectural HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_pendHi <= 32'd0;
         r_pendLo <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_done  <= w_commit;
         if (w_issue) begin
            r_pendHi <= w_resHi;
            r_pendLo <= w_resLo;
         end
         if (w_commit) begin
            r_hi <= r_pendHi;
            r_lo <= r_pendLo;
         end else begin
            if (w_wrHi) r_hi <= rs_val;
            if (w_wrLo) r_lo <= rs_val;
         end
      end
   end

   assign busy  = (r_state == RUN);
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;
   // Covers the issue cycle itself, before busy has risen.
   assign stall = d_is_md & (busy | (op_valid & (md_op <= 3'd3)));

endmodule
